// File: rtl/parking_slot_manager.sv
// Parking slot manager: debounces four slot sensors, runs the entry/exit gate
// handshakes, holds a reservation per admitted car and drives the display values.
module parking_slot_manager #(
  parameter int unsigned DEBOUNCE        = 8,
  parameter int unsigned GATE_CYCLES     = 1000,
  parameter int unsigned RESERVE_TIMEOUT = 15000
) (
  input  logic       clk_500Hz,
  input  logic       reset,
  input  logic [3:0] slot_sensor,
  input  logic       entry_req,
  input  logic       exit_req,
  output logic [2:0] capacity,
  output logic [1:0] first_empty,
  output logic       full,
  output logic       entry_gate_open,
  output logic       exit_gate_open,
  output logic       entry_ack,
  output logic [1:0] entry_slot,
  output logic       entry_denied
);

  localparam int unsigned SLOTS  = 4;
  localparam int unsigned DB_W   = $clog2(DEBOUNCE + 1);
  localparam int unsigned GATE_W = $clog2(GATE_CYCLES + 1);
  localparam int unsigned RES_W  = $clog2(RESERVE_TIMEOUT + 1);

  typedef enum logic [1:0] {E_IDLE, E_GRANT, E_OPEN, E_WAIT} entry_state_t;
  typedef enum logic [1:0] {X_IDLE, X_OPEN, X_WAIT} exit_state_t;

  logic [DB_W-1:0]   db_cnt [SLOTS];
  logic [SLOTS-1:0]  debounced;
  logic [SLOTS-1:0]  reserved_mask;
  logic [SLOTS-1:0]  occ;
  logic [2:0]        free_cnt;
  logic [1:0]        free_idx;
  logic              free_found;

  logic              res_valid;
  logic [1:0]        res_slot;
  logic [RES_W-1:0]  res_timer;

  entry_state_t      entry_state, entry_next;
  exit_state_t       exit_state, exit_next;
  logic [GATE_W-1:0] entry_cnt, exit_cnt;

  // Per-slot debounce: raw must disagree for DEBOUNCE consecutive cycles to flip.
  always_ff @(posedge clk_500Hz or negedge reset) begin
    if (!reset) begin
      debounced <= '0;
      for (int i = 0; i < SLOTS; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        if (slot_sensor[i] == debounced[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE - 1)) begin
          debounced[i] <= slot_sensor[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Effective occupancy and the free-slot statistics derived from it.
  always_comb begin
    reserved_mask = '0;
    if (res_valid) reserved_mask[res_slot] = 1'b1;
    occ        = debounced | reserved_mask;
    free_cnt   = '0;
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (!occ[i]) begin
        free_cnt = free_cnt + 3'd1;
        if (!free_found) begin
          free_idx   = 2'(i);
          free_found = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_500Hz or negedge reset) begin
    if (!reset) begin
      capacity    <= 3'd4;
      first_empty <= '0;
      full        <= 1'b0;
    end else begin
      capacity    <= free_cnt;
      first_empty <= free_idx;
      full        <= (free_cnt == 3'd0);
    end
  end

  // Entry FSM next-state.
  always_comb begin
    entry_next = entry_state;
    case (entry_state)
      E_IDLE:  if (entry_req && !full && !res_valid) entry_next = E_GRANT;
      E_GRANT: entry_next = E_OPEN;
      E_OPEN:  if (entry_cnt == GATE_W'(GATE_CYCLES - 1)) entry_next = E_WAIT;
      E_WAIT:  if (!entry_req) entry_next = E_IDLE;
      default: entry_next = E_IDLE;
    endcase
  end

  // Exit FSM next-state.
  always_comb begin
    exit_next = exit_state;
    case (exit_state)
      X_IDLE:  if (exit_req) exit_next = X_OPEN;
      X_OPEN:  if (exit_cnt == GATE_W'(GATE_CYCLES - 1)) exit_next = X_WAIT;
      X_WAIT:  if (!exit_req) exit_next = X_IDLE;
      default: exit_next = X_IDLE;
    endcase
  end

  always_ff @(posedge clk_500Hz or negedge reset) begin
    if (!reset) begin
      entry_state <= E_IDLE;
      exit_state  <= X_IDLE;
    end else begin
      entry_state <= entry_next;
      exit_state  <= exit_next;
    end
  end

  // Gate timers count only while the FSM stays in OPEN.
  always_ff @(posedge clk_500Hz or negedge reset) begin
    if (!reset) begin
      entry_cnt <= '0;
      exit_cnt  <= '0;
    end else begin
      entry_cnt <= (entry_state == E_OPEN && entry_next == E_OPEN) ? entry_cnt + GATE_W'(1) : '0;
      exit_cnt  <= (exit_state == X_OPEN && exit_next == X_OPEN) ? exit_cnt + GATE_W'(1) : '0;
    end
  end

  // Reservation: set on grant, dropped when the car is sensed or the hold lapses.
  always_ff @(posedge clk_500Hz or negedge reset) begin
    if (!reset) begin
      res_valid <= 1'b0;
      res_slot  <= '0;
      res_timer <= '0;
    end else if (entry_next == E_GRANT) begin
      res_valid <= 1'b1;
      res_slot  <= first_empty;
      res_timer <= RES_W'(RESERVE_TIMEOUT);
    end else if (res_valid) begin
      if (debounced[res_slot] || res_timer == '0) begin
        res_valid <= 1'b0;
      end else begin
        res_timer <= res_timer - RES_W'(1);
      end
    end
  end

  // Handshake outputs are registered from next-state so they align with the state.
  always_ff @(posedge clk_500Hz or negedge reset) begin
    if (!reset) begin
      entry_ack       <= 1'b0;
      entry_slot      <= '0;
      entry_gate_open <= 1'b0;
      exit_gate_open  <= 1'b0;
      entry_denied    <= 1'b0;
    end else begin
      entry_ack       <= (entry_next == E_GRANT);
      entry_gate_open <= (entry_next == E_OPEN);
      exit_gate_open  <= (exit_next == X_OPEN);
      entry_denied    <= entry_req & full;
      if (entry_next == E_GRANT) entry_slot <= first_empty;
    end
  end

endmodule

// File: doc/parking_slot_manager.md
Name: parking_slot_manager

Overview:
Source side of the parking display interface. Tracks occupancy of the 4 parking slots from raw slot sensors and runs the entry and exit gate handshakes. Holds a reservation for each admitted car. Produces the registered capacity (0–4) and first_empty (0–3) values that the 7-segment display driver consumes.

Parameters:
DEBOUNCE, 8, consecutive clk_500Hz cycles a raw sensor must differ from its debounced value before the debounced value flips
GATE_CYCLES, 1000, cycles a gate stays open (2 s at 500 Hz)
RESERVE_TIMEOUT, 15000, cycles a reservation is held before it lapses (30 s)

Ports:
clk_500Hz  input  1  system clock, 500 Hz
reset  input  1  asynchronous, active-low reset
slot_sensor  input  4  raw occupancy sensor per slot, 1 = car present, may bounce
entry_req  input  1  level; car waiting at entry gate
exit_req  input  1  level; car waiting at exit gate
capacity  output  3  number of free slots, 0–4, to display driver
first_empty  output  2  lowest-index free slot, 0–3, to display driver
full  output  1  1 when capacity == 0
entry_gate_open  output  1  entry barrier open
exit_gate_open  output  1  exit barrier open
entry_ack  output  1  one-cycle pulse when an entry is granted
entry_slot  output  2  slot assigned at the last grant; held until the next grant
entry_denied  output  1  high while entry_req is high and full is 1

Behaviour:
- Clock and reset: single clock clk_500Hz. reset is asynchronous, active-low; all state clears immediately on reset low.
- Reset values:
  - capacity = 4, first_empty = 0, full = 0
  - both gates closed; entry_ack, entry_slot, entry_denied = 0
  - debounced occupancy = 0; no reservation pending; both FSMs in IDLE
- Debounce, per slot:
  - Counter increments while raw != debounced; it clears when raw == debounced.
  - When the counter reaches DEBOUNCE, debounced takes the raw value and the counter clears.
  - A glitch shorter than DEBOUNCE cycles has no effect.
- Effective occupancy: occ = debounced | reserved (4 bits).
- Registered outputs, updated from the current-cycle occ, so they lag occ by 1 cycle:
  - capacity = number of zero bits in occ
  - first_empty = lowest index i with occ[i] = 0; when occ = 4'b1111, first_empty = 0
  - full = (capacity == 0)
- Reservation:
  - At most one pending at a time.
  - Set on grant for slot first_empty; the timeout counter loads RESERVE_TIMEOUT.
  - Cleared when that slot's debounced bit becomes 1, or when the counter reaches 0 (car never parked).
  - If both clear conditions occur in the same cycle, the reservation clears.
- Entry FSM, states IDLE, GRANT, OPEN, WAIT_CLEAR:
  - IDLE -> GRANT when entry_req && !full && no reservation pending. With a reservation pending and not full, stay in IDLE; entry_denied stays 0.
  - GRANT (1 cycle): entry_ack = 1, entry_slot = first_empty, reservation set. Go to OPEN.
  - OPEN: entry_gate_open = 1 for exactly GATE_CYCLES cycles. Then go to WAIT_CLEAR.
  - WAIT_CLEAR: gate closed. Return to IDLE once entry_req = 0, so a held request is not granted twice.
  - entry_denied = entry_req & full, registered, in any state.
- Exit FSM, states IDLE, OPEN, WAIT_CLEAR:
  - IDLE -> OPEN on exit_req. exit_gate_open = 1 for GATE_CYCLES cycles, then WAIT_CLEAR, then IDLE once exit_req = 0.
  - The exit gate does not change occupancy; the freed slot shows up through its sensor debounce.
- Concurrency: the entry and exit FSMs are fully independent; simultaneous requests are both served.
- Sensor change during a reservation: a debounced rise on a slot other than the reserved one does not clear the reservation.
- Reset mid-operation (gate open, reservation pending): gates close immediately, reservation drops, all outputs return to reset values.
- Counter widths: ceil(log2(param+1)) bits. No wrap occurs, because every counter saturates or clears at its terminal value.

Test Plan:
1. Reset, all sensors 0 -> capacity = 4, first_empty = 0, full = 0, gates closed.
2. slot_sensor[0] pulses high for 5 cycles -> no change. slot_sensor[0] held high -> capacity = 3 and first_empty = 1 within DEBOUNCE+2 cycles.
3. Sensors 4'b0101, entry_req held high ->
   - entry_ack pulses once, entry_slot = 1
   - capacity drops to 1, first_empty = 3
   - entry_gate_open high exactly 1000 cycles
   - no second grant until entry_req drops
4. Grant on slot 1, sensor never rises -> after 15000 cycles the reservation lapses and capacity/first_empty restore. Same grant with slot_sensor[1] rising -> the reservation clears and capacity is unchanged (occupancy is now sensor-driven).
5. Sensors 4'b1111, entry_req high -> full = 1, entry_denied = 1, no ack, gate stays closed. exit_req asserted in the same cycle -> exit_gate_open for 1000 cycles regardless.
6. Reset low while entry gate open with a reservation pending -> gate closes immediately, capacity returns to the sensor-only count, FSMs in IDLE.
